// File: rtl/video_line_sequencer.sv
// Composite video line sequencer: detects horizontal and vertical sync in a signed
// sample stream and produces burst/active gating, line counters and a lock indication.
module video_line_sequencer #(
    parameter int SYNC_THRESH  = -1024,
    parameter int SYNC_MIN     = 200,
    parameter int SYNC_MAX     = 600,
    parameter int BURST_START  = 394,
    parameter int BURST_LEN    = 186,
    parameter int ACTIVE_START = 700,
    parameter int ACTIVE_LEN   = 3840,
    parameter int LINE_TIMEOUT = 5000,
    parameter int LOCK_LINES   = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               enable_i,
    input  logic signed [11:0] data_in_i,
    output logic signed [11:0] sep_data_o,
    output logic               burst_gate_o,
    output logic               active_valid_o,
    output logic               line_start_o,
    output logic               vsync_pulse_o,
    output logic [12:0]        h_count_o,
    output logic [9:0]         line_count_o,
    output logic               locked_o,
    output logic [2:0]         state_o
);
    typedef enum logic [2:0] {
        S_SEARCH     = 3'd0,
        S_SYNC       = 3'd1,
        S_BACK_PORCH = 3'd2,
        S_ACTIVE     = 3'd3,
        S_FRONT      = 3'd4
    } state_t;

    localparam logic signed [11:0] THRESH = 12'(SYNC_THRESH);
    localparam logic [12:0] RUN_MIN   = 13'(SYNC_MIN);
    localparam logic [12:0] RUN_MAX   = 13'(SYNC_MAX);
    localparam logic [12:0] BURST_BEG = 13'(BURST_START);
    localparam logic [12:0] BURST_END = 13'(BURST_START + BURST_LEN);
    localparam logic [12:0] ACT_BEG   = 13'(ACTIVE_START);
    localparam logic [12:0] ACT_END   = 13'(ACTIVE_START + ACTIVE_LEN);
    localparam logic [12:0] TIMEOUT   = 13'(LINE_TIMEOUT);
    localparam logic [12:0] H_MAX     = 13'h1FFF;
    localparam logic [7:0]  LOCK_N    = 8'(LOCK_LINES);

    state_t             state_q, state_d;
    logic [12:0]        h_q, h_d;
    logic [12:0]        run_q, run_d;
    logic               long_q, long_d;
    logic [9:0]         line_cnt_q, line_cnt_d;
    logic [7:0]         good_q, good_d;
    logic               locked_q, locked_d;
    logic signed [11:0] sep_q, sep_d;
    logic               burst_q, burst_d;
    logic               active_q, active_d;
    logic               line_start_q, line_start_d;
    logic               vsync_q, vsync_d;
    logic               is_sync;

    assign is_sync = data_in_i < THRESH;

    always_comb begin
        state_d      = state_q;
        h_d          = (h_q == H_MAX) ? h_q : h_q + 13'd1;
        run_d        = run_q;
        long_d       = long_q;
        line_cnt_d   = line_cnt_q;
        good_d       = good_q;
        locked_d     = locked_q;
        line_start_d = 1'b0;
        vsync_d      = 1'b0;

        case (state_q)
            S_SEARCH: begin
                if (is_sync) begin
                    state_d = S_SYNC;
                    h_d     = '0;
                    run_d   = 13'd1;
                    long_d  = 1'b0;
                end
            end
            S_SYNC: begin
                if (is_sync) begin
                    // Run counter stops at SYNC_MAX so the vsync pulse fires only once.
                    if (run_q < RUN_MAX) begin
                        run_d = run_q + 13'd1;
                        if (run_d == RUN_MAX) begin
                            vsync_d    = 1'b1;
                            line_cnt_d = '0;
                            long_d     = 1'b1;
                        end
                    end
                end else begin
                    run_d = '0;
                    if (long_q) begin
                        state_d = S_SEARCH;
                    end else if (run_q < RUN_MIN) begin
                        state_d  = S_SEARCH;
                        locked_d = 1'b0;
                        good_d   = '0;
                    end else begin
                        state_d      = S_BACK_PORCH;
                        line_start_d = 1'b1;
                        line_cnt_d   = line_cnt_q + 10'd1;
                    end
                end
            end
            S_BACK_PORCH: begin
                if (h_d == ACT_BEG) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (h_d == ACT_END) state_d = S_FRONT;
            end
            S_FRONT: begin
                if (is_sync) begin
                    state_d = S_SYNC;
                    h_d     = '0;
                    run_d   = 13'd1;
                    long_d  = 1'b0;
                    good_d  = (good_q == 8'hFF) ? good_q : good_q + 8'd1;
                    if (good_d >= LOCK_N) locked_d = 1'b1;
                end else if (h_d >= TIMEOUT) begin
                    state_d  = S_SEARCH;
                    locked_d = 1'b0;
                    good_d   = '0;
                end
            end
            default: state_d = S_SEARCH;
        endcase

        if (!enable_i) begin
            state_d      = S_SEARCH;
            h_d          = '0;
            run_d        = '0;
            long_d       = 1'b0;
            line_cnt_d   = '0;
            good_d       = '0;
            locked_d     = 1'b0;
            line_start_d = 1'b0;
            vsync_d      = 1'b0;
        end

        // Gating is derived from next-state values so it lines up with h_count_o.
        sep_d    = (state_d == S_SYNC) ? 12'sd0 : data_in_i;
        burst_d  = (state_d == S_BACK_PORCH) && (h_d >= BURST_BEG) && (h_d < BURST_END);
        active_d = (state_d == S_ACTIVE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_SEARCH;
            h_q          <= '0;
            run_q        <= '0;
            long_q       <= 1'b0;
            line_cnt_q   <= '0;
            good_q       <= '0;
            locked_q     <= 1'b0;
            sep_q        <= '0;
            burst_q      <= 1'b0;
            active_q     <= 1'b0;
            line_start_q <= 1'b0;
            vsync_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            h_q          <= h_d;
            run_q        <= run_d;
            long_q       <= long_d;
            line_cnt_q   <= line_cnt_d;
            good_q       <= good_d;
            locked_q     <= locked_d;
            sep_q        <= sep_d;
            burst_q      <= burst_d;
            active_q     <= active_d;
            line_start_q <= line_start_d;
            vsync_q      <= vsync_d;
        end
    end

    assign sep_data_o     = sep_q;
    assign burst_gate_o   = burst_q;
    assign active_valid_o = active_q;
    assign line_start_o   = line_start_q;
    assign vsync_pulse_o  = vsync_q;
    assign h_count_o      = h_q;
    assign line_count_o   = line_cnt_q;
    assign locked_o       = locked_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_video_line_sequencer.sv
// Directed bench for video_line_sequencer: short cycle table for thresholds/reset,
// then long hand-written sequences for line trains, glitches, timeout and vsync.
module tb_video_line_sequencer;
    localparam int ST_SEARCH = 0;
    localparam int ST_SYNC   = 1;
    localparam int ST_BP     = 2;
    localparam int ST_ACTIVE = 3;
    localparam int ST_FRONT  = 4;
    localparam int SYNC_W    = 349;
    localparam int LINE_LEN  = 4714;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic signed [11:0] data_in;
    logic signed [11:0] sep_data;
    logic               burst_gate;
    logic               active_valid;
    logic               line_start;
    logic               vsync_pulse;
    logic [12:0]        h_count;
    logic [9:0]         line_count;
    logic               locked;
    logic [2:0]         state;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic r;
        logic e;
        int   d;
        int   st;
        int   h;
        int   sep;
    } vec_t;
    vec_t vecs[12];

    video_line_sequencer dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .enable_i       (enable),
        .data_in_i      (data_in),
        .sep_data_o     (sep_data),
        .burst_gate_o   (burst_gate),
        .active_valid_o (active_valid),
        .line_start_o   (line_start),
        .vsync_pulse_o  (vsync_pulse),
        .h_count_o      (h_count),
        .line_count_o   (line_count),
        .locked_o       (locked),
        .state_o        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input int d);
        rst     = r;
        enable  = e;
        data_in = 12'(d);
        @(posedge clk);
        #1;
    endtask

    // Drives n full lines starting from SEARCH and compares every cycle.
    task automatic run_train(input int n, input int lc0, input int lock_at);
        int e_h, e_ls, e_bg, e_av, e_lk, e_lc, e_st, exp_st;
        for (int i = 0; i < n; i++) begin
            e_h = 0; e_ls = 0; e_bg = 0; e_av = 0; e_lk = 0; e_lc = 0; e_st = 0;
            for (int k = 0; k < LINE_LEN; k++) begin
                step(1'b0, 1'b1, (k < SYNC_W) ? -1500 : 0);
                if (k < SYNC_W)      exp_st = ST_SYNC;
                else if (k < 700)    exp_st = ST_BP;
                else if (k < 4540)   exp_st = ST_ACTIVE;
                else                 exp_st = ST_FRONT;
                if (int'(h_count) != k) e_h++;
                if (int'(state) != exp_st) e_st++;
                if (line_start !== (k == SYNC_W)) e_ls++;
                if (burst_gate !== (k >= 394 && k < 580)) e_bg++;
                if (active_valid !== (k >= 700 && k < 4540)) e_av++;
                if (locked !== (i >= lock_at)) e_lk++;
                if (int'(line_count) != ((k >= SYNC_W) ? lc0 + i + 1 : lc0 + i)) e_lc++;
            end
            check($sformatf("train lc0=%0d line%0d h_count errs", lc0, i), e_h, 0);
            check($sformatf("train lc0=%0d line%0d state errs", lc0, i), e_st, 0);
            check($sformatf("train lc0=%0d line%0d line_start errs", lc0, i), e_ls, 0);
            check($sformatf("train lc0=%0d line%0d burst_gate errs", lc0, i), e_bg, 0);
            check($sformatf("train lc0=%0d line%0d active_valid errs", lc0, i), e_av, 0);
            check($sformatf("train lc0=%0d line%0d locked errs", lc0, i), e_lk, 0);
            check($sformatf("train lc0=%0d line%0d line_count errs", lc0, i), e_lc, 0);
        end
    endtask

    task automatic drive_to_active();
        for (int k = 0; k <= 1000; k++) begin
            step(1'b0, 1'b1, (k < SYNC_W) ? -1500 : ((k >= 700) ? 300 : 0));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ls, n_vs, vs_h, n_bad;
        rst = 1'b1; enable = 1'b1; data_in = '0;

        vecs[0]  = '{1'b1, 1'b1,   100, ST_SEARCH, 0,     0};
        vecs[1]  = '{1'b0, 1'b1, -1025, ST_SYNC,   0,     0};
        vecs[2]  = '{1'b0, 1'b1,     5, ST_SEARCH, 1,     5};
        vecs[3]  = '{1'b0, 1'b1, -1024, ST_SEARCH, 2, -1024};
        vecs[4]  = '{1'b0, 1'b1,  2047, ST_SEARCH, 3,  2047};
        vecs[5]  = '{1'b0, 1'b1, -2048, ST_SYNC,   0,     0};
        vecs[6]  = '{1'b0, 1'b1, -2048, ST_SYNC,   1,     0};
        vecs[7]  = '{1'b0, 1'b0, -2048, ST_SEARCH, 0, -2048};
        vecs[8]  = '{1'b0, 1'b0,    33, ST_SEARCH, 0,    33};
        vecs[9]  = '{1'b0, 1'b1, -1500, ST_SYNC,   0,     0};
        vecs[10] = '{1'b1, 1'b1, -1500, ST_SEARCH, 0,     0};
        vecs[11] = '{1'b0, 1'b1,     7, ST_SEARCH, 1,     7};

        for (int v = 0; v < 12; v++) begin
            step(vecs[v].r, vecs[v].e, vecs[v].d);
            check($sformatf("vec%0d state", v), int'(state), vecs[v].st);
            check($sformatf("vec%0d h_count", v), int'(h_count), vecs[v].h);
            check($sformatf("vec%0d sep_data", v), int'(sep_data), vecs[v].sep);
            check($sformatf("vec%0d line_start", v), int'(line_start), 0);
        end

        // Threshold is strict: -1024 must never start a sync.
        n_bad = 0;
        for (int k = 0; k < 400; k++) begin
            step(1'b0, 1'b1, -1024);
            if (int'(state) != ST_SEARCH) n_bad++;
        end
        check("hold -1024 non-SEARCH cycles", n_bad, 0);
        step(1'b0, 1'b1, -1025);
        check("-1025 enters SYNC", int'(state), ST_SYNC);

        step(1'b1, 1'b1, 0);
        check("reset line_count", int'(line_count), 0);
        check("reset locked", int'(locked), 0);
        run_train(6, 0, 4);

        // Short glitch while locked.
        n_ls = 0;
        for (int k = 0; k < 50; k++) begin
            step(1'b0, 1'b1, -1500);
            if (line_start) n_ls++;
        end
        check("glitch state during sync", int'(state), ST_SYNC);
        check("glitch locked during sync", int'(locked), 1);
        step(1'b0, 1'b1, 0);
        check("glitch state after", int'(state), ST_SEARCH);
        check("glitch locked after", int'(locked), 0);
        check("glitch h_count", int'(h_count), 50);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 0);
            if (line_start) n_ls++;
        end
        check("glitch line_start count", n_ls, 0);
        check("glitch line_count kept", int'(line_count), 6);

        run_train(5, 6, 4);

        // Sync removed after lock.
        for (int k = LINE_LEN; k < 5000; k++) step(1'b0, 1'b1, 0);
        check("timeout state at 4999", int'(state), ST_FRONT);
        check("timeout locked at 4999", int'(locked), 1);
        step(1'b0, 1'b1, 0);
        check("timeout state at 5000", int'(state), ST_SEARCH);
        check("timeout h_count", int'(h_count), 5000);
        check("timeout locked", int'(locked), 0);
        check("timeout line_count kept", int'(line_count), 11);

        // Long sync.
        n_vs = 0; vs_h = -1; n_ls = 0;
        for (int k = 0; k < 2000; k++) begin
            step(1'b0, 1'b1, -1500);
            if (vsync_pulse) begin
                n_vs++;
                vs_h = int'(h_count);
            end
            if (line_start) n_ls++;
        end
        check("vsync pulse count", n_vs, 1);
        check("vsync h_count", vs_h, 599);
        check("vsync line_count", int'(line_count), 0);
        step(1'b0, 1'b1, 0);
        if (line_start) n_ls++;
        check("vsync exit state", int'(state), ST_SEARCH);
        check("vsync line_start count", n_ls, 0);
        check("vsync line_count after exit", int'(line_count), 0);

        // Enable drop mid-ACTIVE.
        step(1'b1, 1'b1, 0);
        drive_to_active();
        check("pre-disable active_valid", int'(active_valid), 1);
        check("pre-disable sep_data", int'(sep_data), 300);
        check("pre-disable line_count", int'(line_count), 1);
        step(1'b0, 1'b0, 300);
        check("disable active_valid", int'(active_valid), 0);
        check("disable state", int'(state), ST_SEARCH);
        check("disable sep_data tracks", int'(sep_data), 300);
        check("disable h_count", int'(h_count), 0);
        check("disable line_count", int'(line_count), 0);

        // Reset mid-ACTIVE.
        drive_to_active();
        check("pre-reset state", int'(state), ST_ACTIVE);
        step(1'b1, 1'b1, 300);
        check("reset active_valid", int'(active_valid), 0);
        check("reset sep_data", int'(sep_data), 0);
        check("reset h_count", int'(h_count), 0);
        check("reset state", int'(state), ST_SEARCH);
        check("reset line_count mid", int'(line_count), 0);
        check("reset burst/ls/vs", int'({burst_gate, line_start, vsync_pulse, locked}), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/video_line_sequencer.md
VIDEO_LINE_SEQUENCER -- requirements
Module: video_line_sequencer

Interface
REQ-001 Parameter SYNC_THRESH, default -1024: signed 12-bit level; a sample strictly below it is a sync sample.
REQ-002 Parameter SYNC_MIN, default 200: minimum sync run length for a valid horizontal sync, in samples.
REQ-003 Parameter SYNC_MAX, default 600: sync run length that classifies the sync as vertical/long.
REQ-004 Parameter BURST_START, default 394; BURST_LEN, default 186: colour-burst window, as h_count values.
REQ-005 Parameter ACTIVE_START, default 700; ACTIVE_LEN, default 3840: active-video window.
REQ-006 Parameter LINE_TIMEOUT, default 5000; LOCK_LINES, default 4.
REQ-007 clk  in  1  sample clock, 74.25 MHz; all logic on the rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 enable  in  1  sequencer run; low forces SEARCH on the next edge.
REQ-010 data_in  in  12 signed  composite sample stream.
REQ-011 sep_data  out  12 signed  data_in delayed one cycle; blanked to 0 during sync; feeds the Y/C separator.
REQ-012 burst_gate  out  1  high inside the burst window.
REQ-013 active_valid  out  1  high inside the active window.
REQ-014 line_start  out  1  one-cycle pulse when a valid hsync ends.
REQ-015 vsync_pulse  out  1  one-cycle pulse when a sync run reaches SYNC_MAX.
REQ-016 h_count  out  13  samples since the sync leading edge; saturates at 8191.
REQ-017 line_count  out  10  valid lines since the last vsync; wraps 1023->0.
REQ-018 locked  out  1  LOCK_LINES consecutive good lines have been seen.

Function
REQ-019 All outputs SHALL be registered; burst_gate, active_valid and state SHALL be coherent with the h_count value output in the same cycle.
REQ-020 The state machine SHALL have five states: SEARCH, SYNC, BACK_PORCH, ACTIVE, FRONT.
REQ-021 SEARCH or FRONT, data_in < SYNC_THRESH: next cycle state=SYNC, h_count=0, run counter=1.
REQ-022 SYNC, data_in < SYNC_THRESH: run counter and h_count increment; at run==SYNC_MAX, vsync_pulse=1 once, line_count=0, long flag set.
REQ-023 SYNC, data_in >= SYNC_THRESH, run < SYNC_MIN: glitch; go to SEARCH, locked=0, good-line count=0.
REQ-024 SYNC exit, long flag set: go to SEARCH; no line_start; locked unchanged.
REQ-025 SYNC exit, SYNC_MIN <= run < SYNC_MAX: go to BACK_PORCH; line_start pulses; line_count increments.
REQ-026 burst_gate=1 iff state=BACK_PORCH and BURST_START <= h_count < BURST_START+BURST_LEN.
REQ-027 BACK_PORCH goes to ACTIVE when h_count==ACTIVE_START; active_valid=1 for exactly ACTIVE_LEN cycles, then FRONT.
REQ-028 Sync-level samples in BACK_PORCH or ACTIVE SHALL be ignored.
REQ-029 FRONT, h_count reaching LINE_TIMEOUT with no sync: go to SEARCH, locked=0, good-line count=0.
REQ-030 FRONT to SYNC transition: good-line count increments (saturating); locked=1 when count >= LOCK_LINES.
REQ-031 sep_data SHALL equal 0 whenever state=SYNC; otherwise it SHALL equal data_in of the previous cycle.
REQ-032 Sync detection SHALL use a signed compare; -2048 is a valid sync sample and +2047 is not.
REQ-033 enable=0 SHALL have the same effect as rst, except that sep_data keeps tracking data_in.
REQ-034 rst or enable=0 during ACTIVE SHALL drop active_valid on the next edge; no partial line is counted.

Reset
REQ-035 On rst: state=SEARCH; sep_data, h_count, line_count, good-line count and run counter = 0; burst_gate, active_valid, line_start, vsync_pulse, locked = 0.
REQ-036 The first sync edge after reset release SHALL be detectable one cycle after rst deasserts.

Verification
REQ-037 Clean NTSC line train (sync -1500 for 349 samples, blank 0, line 4714 samples) x6 -> line_start every 4714 cycles; burst_gate high at h_count 394..579; active_valid 3840 cycles from 700; locked=1 after the 4th line.
REQ-038 Sync pulse of 50 samples -> returns to SEARCH, no line_start, locked=0.
REQ-039 Sync pulse of 2000 samples -> one vsync_pulse at h_count=599, line_count=0, no line_start.
REQ-040 Sync removed after lock -> SEARCH at h_count=5000, locked=0.
REQ-041 rst asserted mid-ACTIVE -> all outputs 0 next cycle; sep_data=0.
REQ-042 data_in=-1024 held for 400 samples -> stays SEARCH (threshold is strict); data_in=-1025 -> SYNC.
